// File: rtl/reflet_irq_pkg.sv
// rtl/reflet_irq_pkg.sv - shared constants for the reflet interrupt front-end
package reflet_irq_pkg;

   localparam int IRQ_LINES   = 4;

   localparam int IRQ_PENDING = 0;
   localparam int IRQ_MASK    = 1;
   localparam int IRQ_MODE    = 2;

   localparam logic [IRQ_LINES-1:0] MASK_RST = 4'hF;
   localparam logic [IRQ_LINES-1:0] MODE_RST = 4'hF;

endpackage

// File: rtl/reflet_sync2.sv
// rtl/reflet_sync2.sv - parameterised-width two-flop synchroniser
module reflet_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two-stage capture of the asynchronous inputs into the clk domain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reflet_irq_ctrl.sv
// rtl/reflet_irq_ctrl.sv - interrupt capture, masking and register file for reflet_cpu
module reflet_irq_ctrl
   import reflet_irq_pkg::*;
#(
   parameter int                 wordsize  = 8,
   parameter logic [wordsize-1:0] base_addr = wordsize'(8'hF0)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [IRQ_LINES-1:0] irq_in,
   input  logic [wordsize-1:0]  addr,
   input  logic [wordsize-1:0]  data_in,
   input  logic                 write_en,
   output logic [wordsize-1:0]  data_out,
   output logic [IRQ_LINES-1:0] interrupt_request
);

   localparam logic [wordsize-1:0] ADDR_PEND = base_addr + wordsize'(IRQ_PENDING);
   localparam logic [wordsize-1:0] ADDR_MASK = base_addr + wordsize'(IRQ_MASK);
   localparam logic [wordsize-1:0] ADDR_MODE = base_addr + wordsize'(IRQ_MODE);

   logic [IRQ_LINES-1:0] s;
   logic [IRQ_LINES-1:0] s_d;
   logic [IRQ_LINES-1:0] pending;
   logic [IRQ_LINES-1:0] mask;
   logic [IRQ_LINES-1:0] mode;
   logic [IRQ_LINES-1:0] set_cond;
   logic [IRQ_LINES-1:0] clr;
   logic [IRQ_LINES-1:0] wr_bits;
   logic [wordsize-1:0]  rd_val;
   logic [1:0]           warm;
   logic                 primed;
   logic                 wr;

   assign wr_bits = data_in[IRQ_LINES-1:0];
   assign wr      = write_en & enable;

   generate
      if (wordsize > IRQ_LINES) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^data_in[wordsize-1:IRQ_LINES];
      end
   endgenerate

   reflet_sync2 #(.WIDTH(IRQ_LINES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (irq_in),
      .q     (s)
   );

   // s_d only holds a genuine sample three edges after reset; until then the
   // zeros left by reset must not look like the low half of a rising edge,
   // otherwise a source held high across reset would re-trigger.
   assign primed = (warm == 2'd3);

   // Set/clear conditions for the pending bits.
   always_comb begin
      set_cond = (mode & s & ~s_d & {IRQ_LINES{primed}}) | (~mode & s);
      clr      = '0;
      if (wr && (addr == ADDR_PEND)) begin
         clr = wr_bits;
      end
   end

   // Read mux: full-width address compare, unused bits read as zero.
   always_comb begin
      rd_val = '0;
      if (addr == ADDR_PEND) begin
         rd_val[IRQ_LINES-1:0] = pending;
      end else if (addr == ADDR_MASK) begin
         rd_val[IRQ_LINES-1:0] = mask;
      end else if (addr == ADDR_MODE) begin
         rd_val[IRQ_LINES-1:0] = mode;
      end
   end

   // Edge-detect history and post-reset warm-up counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_d  <= '0;
         warm <= 2'd0;
      end else begin
         s_d <= s;
         if (!primed) begin
            warm <= warm + 2'd1;
         end
      end
   end

   // Sticky pending bits: a set on the same edge as a clear wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr) | set_cond;
      end
   end

   // MASK and MODE registers, written only while the CPU is running.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask <= MASK_RST;
         mode <= MODE_RST;
      end else begin
         if (wr && (addr == ADDR_MASK)) begin
            mask <= wr_bits;
         end
         if (wr && (addr == ADDR_MODE)) begin
            mode <= wr_bits;
         end
      end
   end

   // Registered outputs: masked request to the CPU and the read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         interrupt_request <= '0;
         data_out          <= '0;
      end else begin
         interrupt_request <= pending & mask;
         data_out          <= rd_val;
      end
   end

endmodule
